booth_seq_mult: RTL and testbench

- Sequential radix-2 Booth multiplier, parametrised in operand width.
- Computes a signed (two's complement) WIDTH×WIDTH product as 2·WIDTH bits, one Booth step per clock.
- Uses a start/busy/done handshake.
- Sits next to the combinational Booth step as the reusable multiply unit for datapaths that can tolerate multi-cycle latency.

---
 rtl/booth_pkg.sv | 20 ++
 rtl/booth_seq_mult_step.sv | 38 +++
 rtl/booth_seq_mult.sv | 136 +++++++++++++
 tb/tb_booth_seq_mult.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier.
//   booth_state_t   : controller state encoding (IDLE, RUN)
//   BOOTH_ADD/SUB   : {Q[0], q_1} pairs that select add / subtract of Mx
//   booth_cnt_width : step-counter width for a given operand width
package booth_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } booth_state_t;

  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  // The counter is loaded with at most WIDTH (unsigned-capable build: N-1 = WIDTH).
  function automatic int booth_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/booth_seq_mult_step.sv
// One combinational radix-2 Booth step: conditional add/subtract of Mx into A,
// then an arithmetic right shift of {A, Q, q_1} by one bit.
// Ports:
//   a, q, q_1, mx        : current partial-product state and extended multiplicand
//   a_next, q_next,
//   q_1_next             : state after the step
// Parameters: AW = width of A and Mx, QW = width of Q.
module booth_step
  import booth_pkg::*;
#(
  parameter int AW = 9,
  parameter int QW = 8
) (
  input  logic [AW-1:0] a,
  input  logic [QW-1:0] q,
  input  logic          q_1,
  input  logic [AW-1:0] mx,
  output logic [AW-1:0] a_next,
  output logic [QW-1:0] q_next,
  output logic          q_1_next
);

  logic [AW-1:0] sum;

  // Add/sub wraps modulo 2^AW; the extra A bit keeps A - Mx in range.
  always_comb begin
    case ({q[0], q_1})
      BOOTH_ADD: sum = a + mx;
      BOOTH_SUB: sum = a - mx;
      default:   sum = a;
    endcase
  end

  assign a_next   = {sum[AW-1], sum[AW-1:1]};
  assign q_next   = {sum[0], q[QW-1:1]};
  assign q_1_next = q[0];

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier, one Booth step per clock, with a
// start/busy/done handshake. Produces the 2*WIDTH-bit two's complement product.
//
// Optional build macro: BOOTH_UNSIGNED_EN
//   defined   : adds port tc (1 = signed, 0 = unsigned), latency WIDTH+1
//   undefined : signed only, latency WIDTH
//
// Ports:
//   clk          : rising-edge clock
//   rst_n        : asynchronous active-low reset
//   start        : request, sampled only in IDLE
//   multiplicand : M operand, captured on the accepting edge
//   multiplier   : Q operand, captured on the accepting edge
//   tc           : signed/unsigned select, sampled with start (macro build only)
//   busy         : high while a multiplication is in progress
//   done         : one-cycle completion pulse
//   product      : last completed result, held until the next completion
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; operands loaded on the accepting edge
// RUN   | one Booth step per clock; last step writes product, pulses done
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
`ifdef BOOTH_UNSIGNED_EN
  input  logic               tc,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

`ifdef BOOTH_UNSIGNED_EN
  localparam int AW    = WIDTH + 2;
  localparam int QW    = WIDTH + 1;
  localparam int NSTEP = WIDTH + 1;
`else
  localparam int AW    = WIDTH + 1;
  localparam int QW    = WIDTH;
  localparam int NSTEP = WIDTH;
`endif
  localparam int              CW       = booth_cnt_width(WIDTH);
  localparam int              AL       = 2 * WIDTH - QW;  // A bits that land in product
  localparam logic [CW-1:0]   CNT_LOAD = CW'(NSTEP - 1);

  booth_state_t  state;
  logic [AW-1:0] a;
  logic [QW-1:0] q;
  logic          q_1;
  logic [AW-1:0] mx;
  logic [CW-1:0] count;

  logic [AW-1:0] a_nxt;
  logic [QW-1:0] q_nxt;
  logic          q_1_nxt;

  logic          ext_m;
  logic [AW-1:0] mx_load;
  logic [QW-1:0] q_load;

`ifdef BOOTH_UNSIGNED_EN
  logic ext_q;
  assign ext_m  = tc & multiplicand[WIDTH-1];
  assign ext_q  = tc & multiplier[WIDTH-1];
  assign q_load = {ext_q, multiplier};
`else
  assign ext_m  = multiplicand[WIDTH-1];
  assign q_load = multiplier;
`endif
  assign mx_load = {{(AW - WIDTH){ext_m}}, multiplicand};

  booth_step #(
    .AW(AW),
    .QW(QW)
  ) u_step (
    .a       (a),
    .q       (q),
    .q_1     (q_1),
    .mx      (mx),
    .a_next  (a_nxt),
    .q_next  (q_nxt),
    .q_1_next(q_1_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a       <= '0;
      q       <= '0;
      q_1     <= 1'b0;
      mx      <= '0;
      count   <= '0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a     <= '0;
            q     <= q_load;
            q_1   <= 1'b0;
            mx    <= mx_load;
            count <= CNT_LOAD;
            state <= RUN;
          end
        end
        RUN: begin
          a   <= a_nxt;
          q   <= q_nxt;
          q_1 <= q_1_nxt;
          if (count == '0) begin
            product <= {a_nxt[AL-1:0], q_nxt};
            done    <= 1'b1;
            state   <= IDLE;
          end else begin
            count <= count - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Flop output: busy is exactly "in RUN", so it never overlaps done.
  assign busy = (state == RUN);

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult: directed vector table and
// multi-cycle sequences on a WIDTH=8 instance, plus a randomized sweep on
// WIDTH = 2, 8 and 16 instances against an arithmetic reference model.
module tb_booth_seq_mult;

`ifdef BOOTH_UNSIGNED_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int NL8  = 8 + EXTRA;
  localparam int NOPS = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int rand_done = 0;
  bit go_rand = 1'b0;
  logic rst_n;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Reference: interpret operands as signed or unsigned integers, multiply,
  // keep the low 2*w bits.
  function automatic logic [63:0] ref_prod(input int w, input logic [31:0] m,
                                           input logic [31:0] q, input logic sgn);
    longint ma, qa, p;
    ma = longint'(m);
    qa = longint'(q);
    if (sgn && m[w-1]) ma = ma - (longint'(1) <<< w);
    if (sgn && q[w-1]) qa = qa - (longint'(1) <<< w);
    p = ma * qa;
    return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  // ---------------- directed WIDTH=8 instance ----------------
  logic        rst8_n;
  logic        start8;
  logic [7:0]  mc8, mp8;
  logic        tc8;
  logic        busy8, done8;
  logic [15:0] prod8;

  booth_seq_mult #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst8_n),
    .start       (start8),
    .multiplicand(mc8),
    .multiplier  (mp8),
`ifdef BOOTH_UNSIGNED_EN
    .tc          (tc8),
`endif
    .busy        (busy8),
    .done        (done8),
    .product     (prod8)
  );

  typedef struct {
    string       name;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        t;
    logic [15:0] e;
  } vec_t;

  // Called at #1 after an edge with the DUT idle (or in its done cycle).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic t,
                        output logic [15:0] p, output int lat, output logic busy_at_done);
    mc8 = a; mp8 = b; tc8 = t; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    mc8 = ~a; mp8 = ~b;
    lat = 0;
    while (done8 !== 1'b1 && lat <= NL8) begin
      @(posedge clk); #1;
      lat++;
    end
    p = prod8;
    busy_at_done = busy8;
  endtask

  // ---------------- random sweep instances ----------------
  for (genvar g = 0; g < 3; g++) begin : gw
    localparam int W  = (g == 0) ? 2 : (g == 1) ? 8 : 16;
    localparam int NL = W + EXTRA;
    logic           start_r;
    logic [W-1:0]   mc_r, mp_r;
    logic           tc_r;
    logic           busy_r, done_r;
    logic [2*W-1:0] prod_r;

    booth_seq_mult #(.WIDTH(W)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start_r),
      .multiplicand(mc_r),
      .multiplier  (mp_r),
`ifdef BOOTH_UNSIGNED_EN
      .tc          (tc_r),
`endif
      .busy        (busy_r),
      .done        (done_r),
      .product     (prod_r)
    );

    initial begin : rnd
      int lat;
      logic [63:0] exp_p;
      bit ok;
      start_r = 1'b0; mc_r = '0; mp_r = '0; tc_r = 1'b1;
      wait (go_rand);
      @(posedge clk); #1;
      for (int i = 0; i < NOPS; i++) begin
        mc_r = W'($urandom);
        mp_r = W'($urandom);
`ifdef BOOTH_UNSIGNED_EN
        tc_r = 1'($urandom);
`endif
        exp_p = ref_prod(W, 32'(mc_r), 32'(mp_r), tc_r);
        start_r = 1'b1;
        @(posedge clk); #1;
        ok = 1'b1;
        lat = 0;
        while (done_r !== 1'b1 && lat <= NL) begin
          if (busy_r !== 1'b1 || done_r !== 1'b0) ok = 1'b0;
          start_r = 1'($urandom);
          mc_r = W'($urandom);
          mp_r = W'($urandom);
          @(posedge clk); #1;
          lat++;
        end
        check($sformatf("rnd_w%0d_lat", W), 64'(lat), 64'(NL));
        check($sformatf("rnd_w%0d_prod", W), 64'(prod_r), exp_p);
        check($sformatf("rnd_w%0d_busy_seq", W), 64'(ok), 64'd1);
        check($sformatf("rnd_w%0d_busy_at_done", W), 64'(busy_r), 64'd0);
        if (lat > NL) break;
        if ($urandom_range(0, 2) == 0) begin
          start_r = 1'b0;
          repeat ($urandom_range(1, 3)) begin
            @(posedge clk); #1;
          end
          check($sformatf("rnd_w%0d_hold", W), 64'(prod_r), exp_p);
        end
      end
      start_r = 1'b0;
      rand_done++;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    vec_t        vt[$];
    logic [15:0] p;
    int          lat;
    logic        bd;
    bit          seen;
    int          budget;

    vt.push_back('{"3x5",       8'd3,   8'd5,   1'b1, 16'h000F});
    vt.push_back('{"m7x6",      8'hF9,  8'd6,   1'b1, 16'hFFD6});
    vt.push_back('{"m128x1",    8'h80,  8'd1,   1'b1, 16'hFF80});
    vt.push_back('{"m128xm128", 8'h80,  8'h80,  1'b1, 16'h4000});
    vt.push_back('{"127x127",   8'h7F,  8'h7F,  1'b1, 16'h3F01});
    vt.push_back('{"127xm128",  8'h7F,  8'h80,  1'b1, 16'hC080});
    vt.push_back('{"m1xm1",     8'hFF,  8'hFF,  1'b1, 16'h0001});
    vt.push_back('{"1xm1",      8'h01,  8'hFF,  1'b1, 16'hFFFF});
    vt.push_back('{"m2x3",      8'hFE,  8'h03,  1'b1, 16'hFFFA});
    vt.push_back('{"0xm5",      8'h00,  8'hFB,  1'b1, 16'h0000});
`ifdef BOOTH_UNSIGNED_EN
    vt.push_back('{"u255x255",  8'hFF,  8'hFF,  1'b0, 16'hFE01});
    vt.push_back('{"u128x128",  8'h80,  8'h80,  1'b0, 16'h4000});
    vt.push_back('{"u128x255",  8'h80,  8'hFF,  1'b0, 16'h7F80});
    vt.push_back('{"u200x3",    8'd200, 8'd3,   1'b0, 16'h0258});
`endif

    rst_n = 1'b0; rst8_n = 1'b0;
    start8 = 1'b0; mc8 = '0; mp8 = '0; tc8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy8), 64'd0);
    check("reset_done", 64'(done8), 64'd0);
    check("reset_prod", 64'(prod8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; rst8_n = 1'b1;
    @(posedge clk); #1;

    foreach (vt[i]) begin
      run_op(vt[i].a, vt[i].b, vt[i].t, p, lat, bd);
      check({vt[i].name, "_prod"}, 64'(p), 64'(vt[i].e));
      check({vt[i].name, "_lat"}, 64'(lat), 64'(NL8));
      check({vt[i].name, "_busy_at_done"}, 64'(bd), 64'd0);
    end

    // start held high: second operation accepted in the done cycle
    mc8 = 8'd2; mp8 = 8'd2; tc8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    mc8 = 8'hA5; mp8 = 8'h3C;
    lat = 0;
    while (done8 !== 1'b1 && lat <= NL8) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_first_lat", 64'(lat), 64'(NL8));
    check("b2b_first_prod", 64'(prod8), 64'h0004);
    mc8 = 8'd3; mp8 = 8'd5;
    lat = 0;
    @(posedge clk); #1;
    lat++;
    check("b2b_accepted", 64'(busy8), 64'd1);
    check("b2b_prod_held", 64'(prod8), 64'h0004);
    mc8 = 8'h7E; mp8 = 8'h81;
    while (done8 !== 1'b1 && lat <= NL8 + 1) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_done_gap", 64'(lat), 64'(NL8 + 1));
    check("b2b_second_prod", 64'(prod8), 64'h000F);
    start8 = 1'b0;
    @(posedge clk); #1;
    check("b2b_idle_after", 64'(busy8), 64'd0);

    // reset 4 edges into 127 x 127
    mc8 = 8'h7F; mp8 = 8'h7F; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("midrst_busy_before", 64'(busy8), 64'd1);
    rst8_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy8), 64'd0);
    check("midrst_done", 64'(done8), 64'd0);
    check("midrst_prod", 64'(prod8), 64'd0);
    @(posedge clk); #1;
    rst8_n = 1'b1;
    seen = 1'b0;
    repeat (NL8 + 3) begin
      @(posedge clk); #1;
      if (done8 === 1'b1 || busy8 === 1'b1) seen = 1'b1;
    end
    check("midrst_no_done", 64'(seen), 64'd0);
    run_op(8'h7F, 8'h7F, 1'b1, p, lat, bd);
    check("after_rst_prod", 64'(p), 64'h3F01);
    check("after_rst_lat", 64'(lat), 64'(NL8));

    // randomized sweep
    go_rand = 1'b1;
    budget = 0;
    while (rand_done < 3 && budget < 80000) begin
      @(posedge clk);
      budget++;
    end
    check("rand_sweep_complete", 64'(rand_done), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
